// File: rtl/cpu_sequencer_pkg.sv
// Shared state encoding and width helper for the 8051 fetch/decode/execute sequencer.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_OPFETCH = 3'd3,
    ST_EXEC    = 3'd4,
    ST_IRQ     = 3'd5
  } seq_state_t;

  // Bit width able to index n values, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Counts consecutive ready-low cycles of a memory access and flags the cycle
// on which the tolerated wait budget runs out.
module cpu_sequencer_wait_timer
  import cpu_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam int TW = clog2w(WAIT_MAX + 1);

  logic [TW-1:0] cnt_q;

  // Timeout fires on the WAIT_MAX-th low cycle itself so the FSM can abandon right away.
  assign timeout = active && !ready && (cnt_q == TW'(WAIT_MAX - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!active || ready || timeout) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8051 core: multi-byte fetch, variable
// execute length, wait-state timeout and interrupt entry at instruction boundaries.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int OPCODE_W   = 8,
  parameter int MAX_BYTES  = 3,
  parameter int MAX_EXEC   = 4,
  parameter int WAIT_MAX   = 15,
  parameter int IRQ_CYCLES = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               ready,
  input  logic [OPCODE_W-1:0]                Opcode,
  input  logic [clog2w(MAX_BYTES+1)-1:0]     dec_len,
  input  logic [clog2w(MAX_EXEC+1)-1:0]      dec_cycles,
  input  logic                               irq,
  input  logic                               irq_en,
  output logic                               Fetch,
  output logic                               Decode,
  output logic                               Execute,
  output logic                               ir_load,
  output logic                               op_load,
  output logic [clog2w(MAX_BYTES)-1:0]       op_idx,
  output logic [clog2w(MAX_EXEC)-1:0]        exec_idx,
  output logic                               last_exec,
  output logic                               pc_inc,
  output logic                               irq_ack,
  output logic                               bus_err
);

  localparam int LW  = clog2w(MAX_BYTES + 1);
  localparam int CW  = clog2w(MAX_EXEC + 1);
  localparam int OW  = clog2w(MAX_BYTES);
  localparam int EW  = clog2w(MAX_EXEC);
  localparam int IW  = clog2w(IRQ_CYCLES);
  localparam int LW1 = LW + 1;
  localparam int CW1 = CW + 1;

  seq_state_t    state_q, state_d;
  logic [LW-1:0] len_q, len_d, len_clamped;
  logic [CW-1:0] cyc_q, cyc_d, cyc_clamped;
  logic [OW-1:0] op_idx_q, op_idx_d;
  logic [EW-1:0] exec_idx_q, exec_idx_d;
  logic [IW-1:0] irq_cnt_q, irq_cnt_d;
  logic          timeout;
  logic          op_last, exec_last, irq_last;
  logic          unused_opcode;

  // The opcode is carried for trace visibility only; sequencing uses the decoder lengths.
  assign unused_opcode = ^Opcode;

  cpu_sequencer_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .active (state_q == ST_FETCH || state_q == ST_OPFETCH),
    .ready  (ready),
    .timeout(timeout)
  );

  // A zero length or cycle count from the decoder means one; oversize values saturate.
  always_comb begin
    len_clamped = dec_len;
    if (dec_len == '0) begin
      len_clamped = LW'(1);
    end else if ({1'b0, dec_len} > LW1'(MAX_BYTES)) begin
      len_clamped = LW'(MAX_BYTES);
    end
    cyc_clamped = dec_cycles;
    if (dec_cycles == '0) begin
      cyc_clamped = CW'(1);
    end else if ({1'b0, dec_cycles} > CW1'(MAX_EXEC)) begin
      cyc_clamped = CW'(MAX_EXEC);
    end
  end

  assign op_last   = (LW'(op_idx_q) == len_q - LW'(1));
  assign exec_last = (CW'(exec_idx_q) == cyc_q - CW'(1));
  assign irq_last  = (irq_cnt_q == IW'(IRQ_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cyc_d      = cyc_q;
    op_idx_d   = op_idx_q;
    exec_idx_d = exec_idx_q;
    irq_cnt_d  = irq_cnt_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (ready) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        len_d      = len_clamped;
        cyc_d      = cyc_clamped;
        exec_idx_d = '0;
        if (len_clamped > LW'(1)) begin
          state_d  = ST_OPFETCH;
          op_idx_d = OW'(1);
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_OPFETCH: begin
        if (timeout) begin
          state_d = ST_FETCH;
        end else if (ready) begin
          if (op_last) begin
            state_d = ST_EXEC;
          end else begin
            op_idx_d = op_idx_q + OW'(1);
          end
        end
      end
      // Interrupts are only taken at the instruction boundary, i.e. the final execute cycle.
      ST_EXEC: begin
        if (exec_last) begin
          if (irq && irq_en) begin
            state_d   = ST_IRQ;
            irq_cnt_d = '0;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          exec_idx_d = exec_idx_q + EW'(1);
        end
      end
      ST_IRQ: begin
        if (irq_last) begin
          state_d = ST_FETCH;
        end else begin
          irq_cnt_d = irq_cnt_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cyc_q      <= '0;
      op_idx_q   <= '0;
      exec_idx_q <= '0;
      irq_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cyc_q      <= cyc_d;
      op_idx_q   <= op_idx_d;
      exec_idx_q <= exec_idx_d;
      irq_cnt_q  <= irq_cnt_d;
    end
  end

  assign Fetch     = (state_q == ST_FETCH);
  assign Decode    = (state_q == ST_DECODE);
  assign Execute   = (state_q == ST_EXEC);
  assign ir_load   = Fetch && ready;
  assign op_load   = (state_q == ST_OPFETCH) && ready;
  assign pc_inc    = ir_load | op_load;
  assign last_exec = Execute && exec_last;
  assign irq_ack   = (state_q == ST_IRQ) && (irq_cnt_q == '0);
  assign bus_err   = timeout;
  assign op_idx    = (state_q == ST_OPFETCH) ? op_idx_q : '0;
  assign exec_idx  = Execute ? exec_idx_q : '0;

endmodule
